// File: rtl/acc_sequencer_pkg.sv
// Shared definitions for the 4-bit accumulator processor: ALU function codes,
// opcode constants, sequencer state encoding and small decode helpers.
package acc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_TARGET = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

    // ALU function select codes
    localparam logic [2:0] F_PASS_A  = 3'b000;
    localparam logic [2:0] F_COMPARE = 3'b001;
    localparam logic [2:0] F_PASS_B  = 3'b010;
    localparam logic [2:0] F_ADD     = 3'b011;
    localparam logic [2:0] F_NOR     = 3'b100;

    // Opcodes (instruction byte bits [7:4])
    localparam logic [3:0] OP_CMPI = 4'h0;
    localparam logic [3:0] OP_CMPM = 4'h1;
    localparam logic [3:0] OP_LIT  = 4'h2;
    localparam logic [3:0] OP_IN   = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_ADDM = 4'h5;
    localparam logic [3:0] OP_NORI = 4'h6;
    localparam logic [3:0] OP_NORM = 4'h7;
    localparam logic [3:0] OP_JC   = 4'h8;
    localparam logic [3:0] OP_JNC  = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'hA;
    localparam logic [3:0] OP_JNZ  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_OUT  = 4'hD;
    localparam logic [3:0] OP_NOP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Two-byte instructions: the following byte is a jump target
    function automatic logic is_jump(input logic [3:0] op);
        return (op >= OP_JC) && (op <= OP_JMP);
    endfunction

    // M-form ALU ops take their operand from data_in instead of imm
    function automatic logic is_mform(input logic [3:0] op);
        return !op[3] && op[0];
    endfunction

endpackage

// File: rtl/acc_sequencer_branch_cond.sv
// Jump condition evaluation from the jump opcode and the current flags.
module acc_sequencer_branch_cond
    import acc_sequencer_pkg::*;
(
    input  logic [3:0] i_op,
    input  logic       i_flag_c,
    input  logic       i_flag_z,
    output logic       o_taken
);

    // Decode the condition; non-jump opcodes never report taken
    always_comb begin
        o_taken = 1'b0;
        case (i_op)
            OP_JC:   o_taken = i_flag_c;
            OP_JNC:  o_taken = !i_flag_c;
            OP_JZ:   o_taken = i_flag_z;
            OP_JNZ:  o_taken = !i_flag_z;
            OP_JMP:  o_taken = 1'b1;
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/acc_sequencer.sv
// Fetch/decode/execute sequencer for the 4-bit accumulator processor.
// Drives the external combinational ALU and owns acc, flags, pc and the
// output port. Instruction bytes arrive over a valid/ready handshake.
module acc_sequencer
    import acc_sequencer_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instr_valid,
    input  logic [7:0]      instr_data,
    output logic            instr_ready,
    output logic [PC_W-1:0] pc,
    input  logic [3:0]      data_in,
    output logic [3:0]      alu_a,
    output logic [3:0]      alu_b,
    output logic [2:0]      alu_f,
    input  logic [3:0]      alu_y,
    input  logic            alu_c,
    input  logic            alu_zero,
    output logic [3:0]      acc,
    output logic            flag_c,
    output logic            flag_z,
    output logic [3:0]      data_out,
    output logic            out_valid,
    output logic            halted
);

    localparam logic [PC_W-1:0] PC_ONE = 1;

    state_t          r_state;
    state_t          w_state_next;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_next;
    logic [7:0]      r_ir;
    logic [7:0]      w_ir_next;
    logic [3:0]      r_acc;
    logic [3:0]      w_acc_next;
    logic            r_flag_c;
    logic            w_flag_c_next;
    logic            r_flag_z;
    logic            w_flag_z_next;
    logic [3:0]      r_data_out;
    logic [3:0]      w_data_out_next;
    logic            r_out_valid;
    logic            w_out_valid_next;

    logic [3:0]      w_op;
    logic [3:0]      w_imm;
    logic            w_taken;
    logic            w_instr_ready;
    logic [3:0]      w_alu_b;
    logic [2:0]      w_alu_f;

    assign w_op  = r_ir[7:4];
    assign w_imm = r_ir[3:0];

    // Jump decision uses the flags as they stand while the target byte arrives
    acc_sequencer_branch_cond u_branch_cond (
        .i_op     (w_op),
        .i_flag_c (r_flag_c),
        .i_flag_z (r_flag_z),
        .o_taken  (w_taken)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, datapath next values and ALU drive
    always_comb begin
        w_state_next     = r_state;
        w_pc_next        = r_pc;
        w_ir_next        = r_ir;
        w_acc_next       = r_acc;
        w_flag_c_next    = r_flag_c;
        w_flag_z_next    = r_flag_z;
        w_data_out_next  = r_data_out;
        w_out_valid_next = 1'b0;
        w_instr_ready    = 1'b0;
        w_alu_f          = F_PASS_A;
        w_alu_b          = w_imm;

        case (r_state)
            ST_FETCH: begin
                w_instr_ready = 1'b1;
                if (instr_valid) begin
                    w_ir_next    = instr_data;
                    w_pc_next    = r_pc + PC_ONE;
                    w_state_next = is_jump(instr_data[7:4]) ? ST_TARGET : ST_EXEC;
                end
            end

            ST_TARGET: begin
                w_instr_ready = 1'b1;
                if (instr_valid) begin
                    w_pc_next    = w_taken ? instr_data[PC_W-1:0] : r_pc + PC_ONE;
                    w_state_next = ST_FETCH;
                end
            end

            ST_EXEC: begin
                w_state_next = ST_FETCH;
                if (is_mform(w_op)) begin
                    w_alu_b = data_in;
                end
                case (w_op)
                    OP_CMPI, OP_CMPM: begin
                        w_alu_f       = F_COMPARE;
                        w_flag_c_next = alu_c;
                        w_flag_z_next = alu_zero;
                    end
                    OP_LIT, OP_IN: begin
                        w_alu_f       = F_PASS_B;
                        w_acc_next    = alu_y;
                        w_flag_c_next = alu_c;
                        w_flag_z_next = alu_zero;
                    end
                    OP_ADDI, OP_ADDM: begin
                        w_alu_f       = F_ADD;
                        w_acc_next    = alu_y;
                        w_flag_c_next = alu_c;
                        w_flag_z_next = alu_zero;
                    end
                    OP_NORI, OP_NORM: begin
                        w_alu_f       = F_NOR;
                        w_acc_next    = alu_y;
                        w_flag_c_next = alu_c;
                        w_flag_z_next = alu_zero;
                    end
                    OP_OUT: begin
                        w_data_out_next  = r_acc;
                        w_out_valid_next = 1'b1;
                    end
                    OP_HALT: begin
                        w_state_next = ST_HALT;
                    end
                    default: begin
                    end
                endcase
            end

            ST_HALT: begin
                w_state_next = ST_HALT;
            end

            default: begin
                w_state_next = ST_FETCH;
            end
        endcase
    end

    // Architectural registers; reset discards any in-flight instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc        <= '0;
            r_ir        <= '0;
            r_acc       <= '0;
            r_flag_c    <= 1'b0;
            r_flag_z    <= 1'b0;
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_pc        <= w_pc_next;
            r_ir        <= w_ir_next;
            r_acc       <= w_acc_next;
            r_flag_c    <= w_flag_c_next;
            r_flag_z    <= w_flag_z_next;
            r_data_out  <= w_data_out_next;
            r_out_valid <= w_out_valid_next;
        end
    end

    assign instr_ready = w_instr_ready;
    assign pc          = r_pc;
    assign alu_a       = r_acc;
    assign alu_b       = w_alu_b;
    assign alu_f       = w_alu_f;
    assign acc         = r_acc;
    assign flag_c      = r_flag_c;
    assign flag_z      = r_flag_z;
    assign data_out    = r_data_out;
    assign out_valid   = r_out_valid;
    assign halted      = (r_state == ST_HALT);

endmodule

// File: tb/tb_acc_sequencer.sv
// Directed bench for acc_sequencer with a behavioural model of the 4-bit ALU.
module tb_acc_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       instr_valid = 1'b0;
    logic [7:0] instr_data = 8'h00;
    logic       instr_ready;
    logic [7:0] pc;
    logic [3:0] data_in = 4'h0;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_f;
    logic [3:0] alu_y;
    logic       alu_c;
    logic       alu_zero;
    logic [3:0] acc;
    logic       flag_c;
    logic       flag_z;
    logic [3:0] data_out;
    logic       out_valid;
    logic       halted;

    int n_tests = 0;
    int n_fail  = 0;

    acc_sequencer #(.PC_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .instr_ready (instr_ready),
        .pc          (pc),
        .data_in     (data_in),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_f       (alu_f),
        .alu_y       (alu_y),
        .alu_c       (alu_c),
        .alu_zero    (alu_zero),
        .acc         (acc),
        .flag_c      (flag_c),
        .flag_z      (flag_z),
        .data_out    (data_out),
        .out_valid   (out_valid),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // Combinational ALU model: pass_a, compare (borrow), pass_b, add, nor
    always_comb begin
        logic [4:0] sum;
        sum   = {1'b0, alu_a} + {1'b0, alu_b};
        alu_y = alu_a;
        alu_c = 1'b0;
        case (alu_f)
            3'b000: alu_y = alu_a;
            3'b001: begin alu_y = alu_a - alu_b; alu_c = (alu_a < alu_b); end
            3'b010: alu_y = alu_b;
            3'b011: begin alu_y = sum[3:0]; alu_c = sum[4]; end
            3'b100: alu_y = ~(alu_a | alu_b);
            default: alu_y = alu_a;
        endcase
        alu_zero = (alu_y == 4'h0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("[TB] check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one byte and complete the handshake on the next edge
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        while (instr_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("ready_timeout", {31'd0, instr_ready}, 32'd1);
        instr_valid = 1'b1;
        instr_data  = b;
        tick();
        instr_valid = 1'b0;
    endtask

    // Single-byte instruction: handshake plus the EXEC cycle
    task automatic run1(input logic [7:0] b);
        send(b);
        tick();
    endtask

    task automatic run2(input logic [7:0] op, input logic [7:0] tgt);
        send(op);
        send(tgt);
    endtask

    initial begin
        // Reset
        tick();
        tick();
        reset = 1'b0;
        check("rst_pc", pc, 8'h00);
        check("rst_acc", acc, 4'h0);
        check("rst_flags", {flag_c, flag_z}, 2'b00);
        check("rst_ready", instr_ready, 1'b1);
        check("rst_halted", halted, 1'b0);

        // 1: LIT 5, ADDI 3, OUT
        run1(8'h25);
        run1(8'h43);
        check("t1_acc", acc, 4'h8);
        check("t1_flags", {flag_c, flag_z}, 2'b00);
        send(8'hD0);
        check("t1_ov_exec", out_valid, 1'b0);
        check("t1_ready_exec", instr_ready, 1'b0);
        tick();
        check("t1_ov_pulse", out_valid, 1'b1);
        check("t1_data_out", data_out, 4'h8);
        check("t1_pc", pc, 8'h03);
        tick();
        check("t1_ov_drop", out_valid, 1'b0);

        // 2: add overflow, then NORM
        run1(8'h2F);
        run1(8'h41);
        check("t2_acc_add", acc, 4'h0);
        check("t2_flags_add", {flag_c, flag_z}, 2'b11);
        run1(8'h25);
        data_in = 4'hA;
        run1(8'h70);
        check("t2_acc_norm", acc, 4'h0);
        check("t2_flags_norm", {flag_c, flag_z}, 2'b01);

        // 3: compare then jumps
        run1(8'h23);
        run1(8'h05);
        check("t3_acc_cmp", acc, 4'h3);
        check("t3_flags_cmp", {flag_c, flag_z}, 2'b10);
        check("t3_pc_pre", pc, 8'h09);
        run2(8'h80, 8'h40);
        check("t3_pc_jc", pc, 8'h40);
        run2(8'hA0, 8'h10);
        check("t3_pc_jz_nt", pc, 8'h42);
        check("t3_flags_keep", {flag_c, flag_z}, 2'b10);

        // 4: stalls in FETCH and TARGET
        repeat (5) tick();
        check("t4_fetch_pc", pc, 8'h42);
        check("t4_fetch_ready", instr_ready, 1'b1);
        check("t4_fetch_acc", acc, 4'h3);
        send(8'hC0);
        repeat (5) tick();
        check("t4_tgt_pc", pc, 8'h43);
        check("t4_tgt_ready", instr_ready, 1'b1);
        check("t4_tgt_flags", {flag_c, flag_z}, 2'b10);
        send(8'h50);
        check("t4_tgt_jmp", pc, 8'h50);

        // 6: pc wrap and jump from top of memory
        run2(8'hC0, 8'hFF);
        check("t6_pc_ff", pc, 8'hFF);
        run1(8'hE0);
        check("t6_pc_wrap", pc, 8'h00);
        run2(8'hC0, 8'hFE);
        run2(8'hC0, 8'h07);
        check("t6_pc_jmp07", pc, 8'h07);

        // 5: HALT absorbs bytes
        send(8'hF0);
        instr_valid = 1'b1;
        instr_data  = 8'h25;
        repeat (20) tick();
        check("t5_halted", halted, 1'b1);
        check("t5_ready", instr_ready, 1'b0);
        check("t5_pc", pc, 8'h08);
        check("t5_acc", acc, 4'h3);
        instr_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_rst_halted", halted, 1'b0);
        check("t5_rst_pc", pc, 8'h00);

        // 5: async reset mid-EXEC of ADDI
        run1(8'h2F);
        run1(8'hD0);
        run1(8'h2F);
        run1(8'h41);
        run1(8'h27);
        run1(8'h09);
        check("t5_pre_acc", acc, 4'h7);
        check("t5_pre_c", flag_c, 1'b1);
        check("t5_pre_dout", data_out, 4'hF);
        send(8'h43);
        #2;
        reset = 1'b1;
        #1;
        check("t5_async_acc", acc, 4'h0);
        check("t5_async_flags", {flag_c, flag_z}, 2'b00);
        check("t5_async_pc", pc, 8'h00);
        check("t5_async_dout", data_out, 4'h0);
        check("t5_async_ov", out_valid, 1'b0);
        check("t5_async_ready", instr_ready, 1'b1);
        tick();
        reset = 1'b0;
        run1(8'h29);
        check("t5_after_acc", acc, 4'h9);
        check("t5_after_pc", pc, 8'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/acc_sequencer.md
Name: acc_sequencer

Overview:
Fetch/decode/execute sequencer for the 4-bit accumulator processor. It sits directly upstream and downstream of the combinational 4-bit ALU.
- Upstream: drives the ALU's a, b and f inputs.
- Downstream: consumes the ALU's y, c_out and zero outputs, and owns the accumulator, C/Z flags, program counter and output port.
- Instructions arrive one byte at a time over a valid/ready handshake from program memory.

Parameters:
PC_W, 8, program counter width; legal range 1..8; jump target = instr_data[PC_W-1:0]

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
instr_valid  in  1  program memory presents a byte on instr_data
instr_data  in  8  instruction byte {op[7:4], imm[3:0]}, or jump-target byte
instr_ready  out  1  sequencer accepts a byte this cycle; combinational from state
pc  out  PC_W  address of the next byte to fetch
data_in  in  4  external operand for M-form ops; sampled in EXEC
alu_a  out  4  ALU operand a; always acc
alu_b  out  4  ALU operand b; imm, or data_in for M-form ops
alu_f  out  3  ALU function: 000 pass_a, 001 compare, 010 pass_b, 011 add, 100 nor
alu_y  in  4  ALU result
alu_c  in  1  ALU carry/borrow
alu_zero  in  1  ALU zero flag
acc  out  4  accumulator
flag_c  out  1  carry flag; after compare, 1 = acc < operand (unsigned borrow)
flag_z  out  1  zero flag
data_out  out  4  output port register
out_valid  out  1  one-cycle pulse when data_out updates
halted  out  1  high in HALT state

Behaviour:
- Reset (async, immediate): state=FETCH, pc=0, IR=0, acc=0, flag_c=0, flag_z=0, data_out=0, out_valid=0, halted=0.
- Reset mid-operation discards the in-flight instruction. Upstream restarts at pc 0.
- The ALU's own reset input is tied to system reset at top level; this block does not drive it.

Opcodes (op[7:4]):
- 0 CMPI, 1 CMPM: f=001; flags updated; acc unchanged.
- 2 LIT, 3 IN: f=010; acc<=operand; flags updated (ALU gives C=0).
- 4 ADDI, 5 ADDM: f=011; acc<=y; C=carry out of bit 3.
- 6 NORI, 7 NORM: f=100; acc<=y; flags updated.
- 8 JC, 9 JNC, A JZ, B JNZ, C JMP: two-byte instructions; next byte is the target.
- D OUT, E NOP, F HALT.

States:
- FETCH:
  - instr_ready=1.
  - On handshake (instr_valid & instr_ready): IR<=instr_data, pc<=pc+1.
  - Next state: TARGET if op in 8..C, else EXEC.
  - Without instr_valid: hold; no register changes.
- TARGET:
  - instr_ready=1; waits for the target byte.
  - On handshake: pc <= taken ? instr_data[PC_W-1:0] : pc+1; next FETCH.
  - taken is evaluated on the current flag_c/flag_z. Jumps never modify flags.
- EXEC:
  - instr_ready=0; single cycle; next FETCH.
  - ALU ops: flag_c<=alu_c, flag_z<=alu_zero; acc written as per the opcode list.
  - OUT: data_out<=acc; out_valid=1 for exactly the following cycle.
  - NOP: no change.
  - HALT: next state is HALT instead of FETCH.
- HALT: instr_ready=0, halted=1; absorbing until reset.

ALU drive and widths:
- Outside EXEC: alu_f=000, alu_b=imm, alu_a=acc.
- All ALU arithmetic is 4-bit modulo; the carry/borrow goes to flag_c only.
- pc increments wrap modulo 2^PC_W (e.g. 0xFF -> 0x00).

Timing:
- Latency: single-byte instruction = 2 cycles min (FETCH+EXEC); jump = 2 cycles min (FETCH+TARGET).
- Results are visible on acc/flags the cycle after EXEC.
- Stalls: instr_valid low in FETCH/TARGET stalls indefinitely with all state held.
- The sequencer never accepts a byte outside FETCH/TARGET.

Decomposition:
- Shared defines/package (also used by alu): f codes PASS_A/COMPARE/PASS_B/ADD/NOR, opcode constants OP_CMPI..OP_HALT, state encodings.
- A single module is sufficient.
- Optional sub-module: branch_cond (op[3:0], flag_c, flag_z -> taken), purely combinational.

Test Plan:
1. Reset, then bytes 0x25, 0x43, 0xD0 -> acc=8, C=0, Z=0; data_out=8; out_valid high exactly 1 cycle; pc=3.
2. LIT F (0x2F), ADDI 1 (0x41) -> acc=0, C=1, Z=1. Then NORM with data_in=0xA after LIT 5 -> acc=0, Z=1, C=0.
3. LIT 3, CMPI 5 (0x05) -> acc=3, C=1, Z=0. JC 0x80, 0x40 -> pc=0x40. Then JZ 0xA0, 0x10 not taken -> pc=0x42.
4. instr_valid low for 5 cycles in FETCH, and separately in TARGET -> pc, acc, flags and state unchanged; instr_ready stays 1.
5. HALT (0xF0) with instr_valid held high 20 cycles -> halted=1, instr_ready=0, pc frozen. Async reset asserted mid-EXEC of ADDI -> all outputs 0 before the next clock edge.
6. Drive pc to 0xFF, fetch NOP (0xE0) -> pc=0x00. JMP at 0xFE with target 0x07 -> pc=0x07.
